// File: rtl/dnd_event_classifier.sv
// dnd_event_classifier: buffers events awaiting MLP scores, thresholds them and forwards signal events.
module dnd_event_classifier #(
    parameter int CAVIAR_X_Y_BITS = 9,
    parameter int TIMESTAMP_BITS  = 16,
    parameter int W_Y             = 17,
    parameter int DEPTH           = 8,
    parameter int CNT_W           = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*CAVIAR_X_Y_BITS:0]   evt_in,
    input  logic [TIMESTAMP_BITS-1:0]    evt_ts_in,
    input  logic                         evt_in_vld,
    input  logic [W_Y-1:0]               mlp_out,
    input  logic                         mlp_out_vld,
    input  logic [W_Y-1:0]               threshold,
    input  logic                         filter_en,
    output logic [2*CAVIAR_X_Y_BITS:0]   evt_out,
    output logic [TIMESTAMP_BITS-1:0]    evt_ts_out,
    output logic [W_Y-1:0]               evt_score_out,
    output logic                         evt_out_vld,
    input  logic                         evt_out_rdy,
    output logic [CNT_W-1:0]             pass_cnt,
    output logic [CNT_W-1:0]             noise_cnt,
    output logic [CNT_W-1:0]             loss_cnt,
    output logic [$clog2(DEPTH):0]       pending,
    output logic                         err_orphan
);
    localparam int EW = 2*CAVIAR_X_Y_BITS+1;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW+1;

    logic [EW-1:0]             evt_mem_q [DEPTH];
    logic [TIMESTAMP_BITS-1:0] ts_mem_q  [DEPTH];
    logic [AW-1:0]             rd_q, rd_d, wr_q, wr_d;
    logic [PW-1:0]             cnt_q, cnt_d;
    logic                      vld_q, vld_d, err_q, err_d;
    logic [EW-1:0]             evt_q, evt_d;
    logic [TIMESTAMP_BITS-1:0] ts_q, ts_d;
    logic [W_Y-1:0]            score_q, score_d;
    logic [CNT_W-1:0]          pass_q, pass_d, noise_q, noise_d, loss_q, loss_d;
    logic                      empty, full, pop, push, is_sig, out_free, load, busy_drop;
    logic [1:0]                loss_inc;

    // An input drop and a busy-output drop can coincide, so increments reach 2.
    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_comb begin
        empty     = cnt_q == '0;
        full      = cnt_q == PW'(DEPTH);
        pop       = mlp_out_vld && !empty;
        push      = evt_in_vld && (!full || pop);
        is_sig    = !filter_en || ($signed(mlp_out) >= $signed(threshold));
        out_free  = !vld_q || evt_out_rdy;
        load      = pop && is_sig && out_free;
        busy_drop = pop && is_sig && !out_free;
        loss_inc  = {1'b0, evt_in_vld && !push} + {1'b0, busy_drop};
        rd_d      = rd_q + AW'(pop);
        wr_d      = wr_q + AW'(push);
        cnt_d     = cnt_q + PW'(push) - PW'(pop);
        vld_d     = load || (vld_q && !evt_out_rdy);
        evt_d     = load ? evt_mem_q[rd_q] : evt_q;
        ts_d      = load ? ts_mem_q[rd_q] : ts_q;
        score_d   = load ? mlp_out : score_q;
        pass_d    = sat(pass_q, {1'b0, load});
        noise_d   = sat(noise_q, {1'b0, pop && !is_sig});
        loss_d    = sat(loss_q, loss_inc);
        err_d     = err_q || (mlp_out_vld && empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            evt_q   <= '0;
            ts_q    <= '0;
            score_q <= '0;
            pass_q  <= '0;
            noise_q <= '0;
            loss_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            evt_q   <= evt_d;
            ts_q    <= ts_d;
            score_q <= score_d;
            pass_q  <= pass_d;
            noise_q <= noise_d;
            loss_q  <= loss_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            evt_mem_q[wr_q] <= evt_in;
            ts_mem_q[wr_q]  <= evt_ts_in;
        end
    end

    assign evt_out       = evt_q;
    assign evt_ts_out    = ts_q;
    assign evt_score_out = score_q;
    assign evt_out_vld   = vld_q;
    assign pass_cnt      = pass_q;
    assign noise_cnt     = noise_q;
    assign loss_cnt      = loss_q;
    assign pending       = cnt_q;
    assign err_orphan    = err_q;
endmodule

// File: tb/tb_dnd_event_classifier.sv
// tb_dnd_event_classifier: directed self-checking bench; a CNT_W=2 twin shares stimulus to show saturation.
module tb_dnd_event_classifier;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] evt_in = '0;
    logic [15:0] evt_ts_in = '0;
    logic        evt_in_vld = 1'b0;
    logic [16:0] mlp_out = '0;
    logic        mlp_out_vld = 1'b0;
    logic [16:0] threshold = 17'd200;
    logic        filter_en = 1'b1;
    logic        evt_out_rdy = 1'b1;
    logic [18:0] evt_out;
    logic [15:0] evt_ts_out;
    logic [16:0] evt_score_out;
    logic        evt_out_vld;
    logic [15:0] pass_cnt, noise_cnt, loss_cnt;
    logic [3:0]  pending;
    logic        err_orphan;
    logic [18:0] s_evt_out;
    logic [15:0] s_evt_ts_out;
    logic [16:0] s_evt_score_out;
    logic        s_evt_out_vld;
    logic [1:0]  s_pass, s_noise, s_loss;
    logic [3:0]  s_pending;
    logic        s_err;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dnd_event_classifier dut (
        .clk(clk), .rst(rst), .evt_in(evt_in), .evt_ts_in(evt_ts_in), .evt_in_vld(evt_in_vld),
        .mlp_out(mlp_out), .mlp_out_vld(mlp_out_vld), .threshold(threshold), .filter_en(filter_en),
        .evt_out(evt_out), .evt_ts_out(evt_ts_out), .evt_score_out(evt_score_out),
        .evt_out_vld(evt_out_vld), .evt_out_rdy(evt_out_rdy), .pass_cnt(pass_cnt),
        .noise_cnt(noise_cnt), .loss_cnt(loss_cnt), .pending(pending), .err_orphan(err_orphan)
    );

    dnd_event_classifier #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .evt_in(evt_in), .evt_ts_in(evt_ts_in), .evt_in_vld(evt_in_vld),
        .mlp_out(mlp_out), .mlp_out_vld(mlp_out_vld), .threshold(threshold), .filter_en(filter_en),
        .evt_out(s_evt_out), .evt_ts_out(s_evt_ts_out), .evt_score_out(s_evt_score_out),
        .evt_out_vld(s_evt_out_vld), .evt_out_rdy(evt_out_rdy), .pass_cnt(s_pass),
        .noise_cnt(s_noise), .loss_cnt(s_loss), .pending(s_pending), .err_orphan(s_err)
    );

    function automatic logic [18:0] ev(input int x, input int y, input int p);
        logic [8:0] xv, yv;
        logic       pv;
        xv = x[8:0];
        yv = y[8:0];
        pv = p[0];
        return {xv, yv, pv};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [18:0] e, input int ts);
        evt_in = e;
        evt_ts_in = ts[15:0];
        evt_in_vld = 1'b1;
        step();
        evt_in_vld = 1'b0;
    endtask

    task automatic score(input int s);
        mlp_out = s[16:0];
        mlp_out_vld = 1'b1;
        step();
        mlp_out_vld = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_pending", pending, 0);
        chk("rst_vld", evt_out_vld, 0);
        chk("rst_evt", evt_out, 0);
        chk("rst_ts", evt_ts_out, 0);
        chk("rst_score", evt_score_out, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_noise", noise_cnt, 0);
        chk("rst_loss", loss_cnt, 0);
        chk("rst_err", err_orphan, 0);

        push(ev(5, 7, 1), 100);
        chk("t1_pending1", pending, 1);
        repeat (40) step();
        score(500);
        chk("t1_vld", evt_out_vld, 1);
        chk("t1_evt", evt_out, ev(5, 7, 1));
        chk("t1_ts", evt_ts_out, 100);
        chk("t1_score", evt_score_out, 500);
        chk("t1_pass", pass_cnt, 1);
        chk("t1_pending0", pending, 0);
        step();
        chk("t1_vld_clr", evt_out_vld, 0);

        threshold = 17'd199;
        push(ev(1, 1, 0), 11);
        push(ev(2, 2, 1), 12);
        push(ev(3, 3, 0), 13);
        chk("t2_pending3", pending, 3);
        score(-10);
        chk("t2_noise_vld", evt_out_vld, 0);
        chk("t2_noise", noise_cnt, 1);
        score(300);
        chk("t2_b_evt", evt_out, ev(2, 2, 1));
        chk("t2_b_ts", evt_ts_out, 12);
        chk("t2_b_score", evt_score_out, 300);
        score(199);
        chk("t2_c_vld", evt_out_vld, 1);
        chk("t2_c_evt", evt_out, ev(3, 3, 0));
        chk("t2_c_score", evt_score_out, 199);
        chk("t2_pass", pass_cnt, 3);
        chk("t2_noise_keep", noise_cnt, 1);
        step();
        filter_en = 1'b0;
        push(ev(4, 4, 1), 14);
        score(-10);
        chk("t2_nf_vld", evt_out_vld, 1);
        chk("t2_nf_evt", evt_out, ev(4, 4, 1));
        chk("t2_nf_score", evt_score_out, 17'h1fff6);
        chk("t2_nf_pass", pass_cnt, 4);
        chk("t2_nf_noise", noise_cnt, 1);
        filter_en = 1'b1;
        step();

        for (int i = 0; i < 10; i++) push(ev(i + 16, i, i % 2), 200 + i);
        chk("t3_pending_full", pending, 8);
        chk("t3_loss", loss_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            score(1000);
            chk("t3_evt", evt_out, ev(i + 16, i, i % 2));
            chk("t3_ts", evt_ts_out, 200 + i);
        end
        chk("t3_pending_empty", pending, 0);
        for (int i = 0; i < 8; i++) push(ev(i + 40, i + 3, 1), 300 + i);
        chk("t3_wrap_pending", pending, 8);
        for (int i = 0; i < 8; i++) begin
            score(1000);
            chk("t3_wrap_ts", evt_ts_out, 300 + i);
            chk("t3_wrap_evt", evt_out, ev(i + 40, i + 3, 1));
        end
        chk("t3_pass", pass_cnt, 20);
        step();
        chk("t3_vld_clr", evt_out_vld, 0);

        evt_out_rdy = 1'b0;
        push(ev(7, 8, 1), 400);
        push(ev(9, 9, 0), 401);
        score(1000);
        chk("t4_vld", evt_out_vld, 1);
        chk("t4_pass", pass_cnt, 21);
        score(1000);
        chk("t4_loss", loss_cnt, 3);
        chk("t4_hold_evt", evt_out, ev(7, 8, 1));
        chk("t4_hold_ts", evt_ts_out, 400);
        chk("t4_pending", pending, 0);
        step();
        chk("t4_hold_vld", evt_out_vld, 1);
        chk("t4_hold_ts2", evt_ts_out, 400);
        evt_out_rdy = 1'b1;
        step();
        chk("t4_xfer_vld", evt_out_vld, 0);
        chk("t4_pass_keep", pass_cnt, 21);

        score(5);
        chk("t5_err", err_orphan, 1);
        chk("t5_vld", evt_out_vld, 0);
        chk("t5_pass", pass_cnt, 21);
        chk("t5_noise", noise_cnt, 1);
        for (int i = 0; i < 8; i++) push(ev(i, i + 1, 0), 500 + i);
        chk("t5_full", pending, 8);
        evt_in = ev(60, 61, 1);
        evt_ts_in = 16'd600;
        evt_in_vld = 1'b1;
        mlp_out = 17'd1000;
        mlp_out_vld = 1'b1;
        step();
        evt_in_vld = 1'b0;
        mlp_out_vld = 1'b0;
        evt_out_rdy = 1'b0;
        chk("t5_pp_pending", pending, 8);
        chk("t5_pp_loss", loss_cnt, 3);
        chk("t5_pp_ts", evt_ts_out, 500);
        chk("t5_pp_pass", pass_cnt, 22);
        chk("t5_err_sticky", err_orphan, 1);

        repeat (3) score(1000);
        chk("t6_pending5", pending, 5);
        chk("t6_vld", evt_out_vld, 1);
        chk("t6_loss", loss_cnt, 6);
        chk("sat_pass", s_pass, 3);
        chk("sat_loss", s_loss, 3);
        chk("sat_noise", s_noise, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        evt_out_rdy = 1'b1;
        chk("t6_pending0", pending, 0);
        chk("t6_vld0", evt_out_vld, 0);
        chk("t6_evt0", evt_out, 0);
        chk("t6_pass0", pass_cnt, 0);
        chk("t6_noise0", noise_cnt, 0);
        chk("t6_loss0", loss_cnt, 0);
        chk("t6_err0", err_orphan, 0);
        chk("sat_pass0", s_pass, 0);
        step();
        chk("t6_vld_stays0", evt_out_vld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dnd_event_classifier.md
Name: dnd_event_classifier

Overview:
Downstream stage of the MLP denoiser top. It buffers each incoming CAVIAR event while the serial MLP computes that event's score. When the score arrives, it pairs the score with the oldest buffered event, thresholds it, and forwards signal events to the sink with valid/ready. It also keeps saturating pass, noise and loss statistics.

Parameters:
CAVIAR_X_Y_BITS, 9, x/y field width; event word is 2*CAVIAR_X_Y_BITS+1 bits (x, y, polarity)
TIMESTAMP_BITS, 16, timestamp width carried with each event
W_Y, 17, MLP score width, two's complement
DEPTH, 8, pending-event FIFO depth, power of two, >= 2
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
evt_in  in  2*CAVIAR_X_Y_BITS+1  CAVIAR event entering the MLP pipeline
evt_ts_in  in  TIMESTAMP_BITS  timestamp of evt_in
evt_in_vld  in  1  evt_in/evt_ts_in valid, 1-cycle pulse, no backpressure
mlp_out  in  W_Y  MLP score, signed
mlp_out_vld  in  1  mlp_out valid, 1-cycle pulse, in event order
threshold  in  W_Y  signed decision threshold, quasi-static
filter_en  in  1  1 = threshold filtering; 0 = pass every scored event
evt_out  out  2*CAVIAR_X_Y_BITS+1  forwarded event
evt_ts_out  out  TIMESTAMP_BITS  forwarded timestamp
evt_score_out  out  W_Y  score of forwarded event
evt_out_vld  out  1  output valid
evt_out_rdy  in  1  sink ready
pass_cnt  out  CNT_W  events forwarded (accepted into the output register)
noise_cnt  out  CNT_W  events classified as noise
loss_cnt  out  CNT_W  events lost: FIFO full, or output register busy
pending  out  $clog2(DEPTH)+1  FIFO occupancy
err_orphan  out  1  sticky: score arrived with the FIFO empty

Behaviour:
- Reset (synchronous, rst=1 at posedge): FIFO emptied (pending=0). evt_out_vld=0. evt_out, evt_ts_out, evt_score_out=0. All counters=0. err_orphan=0. Reset mid-operation discards pending events and any held output without counting them.
- FIFO push when evt_in_vld=1 and (not full, or a pop occurs the same cycle).
- evt_in_vld with the FIFO full and no same-cycle pop: event discarded, loss_cnt+1.
- FIFO pop when mlp_out_vld=1 and pending>0. The head event pairs with mlp_out.
- Push and pop in the same cycle: pending unchanged. Read/write pointers wrap modulo DEPTH.
- mlp_out_vld with pending=0: score discarded, err_orphan<=1. There is no bypass: a push in the same cycle does not pair with that score.
- Decision on pop: signal if filter_en=0 or $signed(mlp_out) >= $signed(threshold); otherwise noise, noise_cnt+1.
- Signal handling:
  - If the output register is free (evt_out_vld=0, or evt_out_rdy=1 this cycle): load evt_out/evt_ts_out/evt_score_out, evt_out_vld<=1, pass_cnt+1. Latency: mlp_out_vld at cycle t gives evt_out_vld=1 at t+1.
  - If the register is busy (evt_out_vld=1 and evt_out_rdy=0): new event dropped, loss_cnt+1. Held output is unchanged.
- Output handshake: transfer when evt_out_vld & evt_out_rdy. evt_out_vld clears after transfer unless reloaded in the same cycle. Data is stable while vld=1 and rdy=0.
- All counters saturate at 2^CNT_W-1, no wrap. err_orphan clears only on rst.
- threshold and filter_en are sampled in the pop cycle.

Test Plan:
- Reset, then evt_in={x=5,y=7,pol=1}, ts=100; 40 cycles later mlp_out=500, threshold=200, rdy=1 -> next cycle evt_out_vld=1 with the same event, ts=100, score=500; pass_cnt=1, pending 1->0.
- Three events, then scores -10, 300, 199 with threshold=199 -> events 2 and 3 forwarded in order, noise_cnt=1, pass_cnt=2. Repeat with filter_en=0 -> pass_cnt=3.
- 10 evt_in pulses, no scores, DEPTH=8 -> pending=8, loss_cnt=2. Then 8 scores of 1000 with rdy=1 -> the first 8 events exit in order; pointer wrap is verified by 8 more events.
- rdy=0, two signal scores back to back -> the first is held stable, the second is lost (loss_cnt=1). Raise rdy -> one transfer, then evt_out_vld=0.
- mlp_out_vld with pending=0 -> err_orphan=1, no output. Push + pop with pending=8 in the same cycle -> push accepted, pending stays 8, loss_cnt unchanged.
- Assert rst with pending=5 and evt_out_vld=1 -> next cycle pending=0, vld=0, counters=0. Saturation: force near-max counters -> they hold at 2^CNT_W-1.
